button_event_gen: RTL and testbench

//  - Consumes the debounced, clock-synchronous button vector from debounce_generic.
//  - Turns each button level into single-cycle event pulses: press, release,

---
 rtl/button_event_gen_pkg.sv | 28 ++
 rtl/button_event_gen_chan.sv | 98 +++++++++
 rtl/button_event_gen.sv | 51 +++++
 tb/tb_button_event_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/button_event_gen_pkg.sv
// Shared types and helpers for the button event generator.
// "release" and "repeat" are reserved words, so those events are named rel and rpt.
package button_event_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESS  = 2'd1,
        ST_REPEAT = 2'd2
    } bev_state_e;

    typedef struct packed {
        logic press;
        logic rel;
        logic hold;
        logic rpt;
        logic held;
    } bev_evt_t;

    function automatic int unsigned bev_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/button_event_gen_chan.sv
// One button channel: turns a debounced level into press/release/hold/repeat pulses.
module button_event_gen_chan
    import button_event_gen_pkg::*;
#(
    parameter int unsigned HOLD_TICKS   = 50,
    parameter int unsigned REPEAT_TICKS = 10
) (
    input  logic clk,
    input  logic clr,
    input  logic tick,
    input  logic db_in,
    output logic press,
    output logic rel,
    output logic hold,
    output logic rpt,
    output logic held
);

    localparam int unsigned HW = bev_clog2(HOLD_TICKS);
    localparam int unsigned RW = bev_clog2(REPEAT_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_TICKS - 1);

    bev_state_e    state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          prev_q;
    bev_evt_t      evt_q, evt_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            rcnt_q  <= '0;
            prev_q  <= 1'b0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            rcnt_q  <= rcnt_d;
            prev_q  <= db_in;
            evt_q   <= evt_d;
        end
    end

    // A release always wins over a tick landing in the same cycle.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        rcnt_d  = rcnt_q;
        evt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (db_in && !prev_q) begin
                    evt_d.press = 1'b1;
                    state_d     = ST_PRESS;
                    hcnt_d      = '0;
                end
            end
            ST_PRESS: begin
                if (!db_in) begin
                    evt_d.rel = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tick) begin
                    if (hcnt_q == HOLD_LAST) begin
                        evt_d.hold = 1'b1;
                        state_d    = ST_REPEAT;
                        rcnt_d     = '0;
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
            end
            ST_REPEAT: begin
                if (!db_in) begin
                    evt_d.rel = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tick) begin
                    if (rcnt_q == RPT_LAST) begin
                        evt_d.rpt = 1'b1;
                        rcnt_d    = '0;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        evt_d.held = (state_d == ST_REPEAT);
    end

    assign press = evt_q.press;
    assign rel   = evt_q.rel;
    assign hold  = evt_q.hold;
    assign rpt   = evt_q.rpt;
    assign held  = evt_q.held;

endmodule

// File: rtl/button_event_gen.sv
// Button event generator: one free-running tick prescaler shared by N independent channels.
module button_event_gen
    import button_event_gen_pkg::*;
#(
    parameter int unsigned N            = 1,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned HOLD_TICKS   = 50,
    parameter int unsigned REPEAT_TICKS = 10
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] db_in,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,
    output logic [N-1:0] hold,
    output logic [N-1:0] rpt,
    output logic [N-1:0] held
);

    localparam int unsigned CW = bev_clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          tick;

    // Prescaler is never restarted by button activity, only by clr.
    always_ff @(posedge clk) begin
        if (clr || tick) cnt_q <= '0;
        else             cnt_q <= cnt_q + CW'(1);
    end

    assign tick = (cnt_q == CNT_LAST);

    for (genvar i = 0; i < int'(N); i++) begin : g_chan
        button_event_gen_chan #(
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_chan (
            .clk   (clk),
            .clr   (clr),
            .tick  (tick),
            .db_in (db_in[i]),
            .press (press[i]),
            .rel   (rel[i]),
            .hold  (hold[i]),
            .rpt   (rpt[i]),
            .held  (held[i])
        );
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed testbench for button_event_gen with N=2, TICK_DIV=4, HOLD_TICKS=3, REPEAT_TICKS=2.
module tb_button_event_gen;

    localparam int N            = 2;
    localparam int TICK_DIV     = 4;
    localparam int HOLD_TICKS   = 3;
    localparam int REPEAT_TICKS = 2;
    localparam int HOLD_MAX     = HOLD_TICKS * TICK_DIV;
    localparam int RPT_GAP      = REPEAT_TICKS * TICK_DIV;

    localparam int EV_PRESS = 0;
    localparam int EV_REL   = 1;
    localparam int EV_HOLD  = 2;
    localparam int EV_RPT   = 3;

    typedef struct {
        int kind;
        int ch;
        int pc;
    } ev_t;

    logic         clk   = 1'b0;
    logic         clr   = 1'b1;
    logic [N-1:0] db_in = 2'b11;
    logic [N-1:0] press, rel, hold, rpt, held;

    ev_t          evq[$];
    logic [N-1:0] heldm = '0;
    int pc = 0;
    int rc = 0;
    int vectors = 0;
    int miscompares = 0;

    button_event_gen #(
        .N            (N),
        .TICK_DIV     (TICK_DIV),
        .HOLD_TICKS   (HOLD_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) dut (
        .clk   (clk),
        .clr   (clr),
        .db_in (db_in),
        .press (press),
        .rel   (rel),
        .hold  (hold),
        .rpt   (rpt),
        .held  (held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, pc, obs, exp);
        end
    endtask

    // One clock: sample at negedge, log pulses, check held against a hold/release tracker.
    task automatic step();
        @(negedge clk);
        pc++;
        for (int i = 0; i < N; i++) begin
            if (press[i]) evq.push_back('{EV_PRESS, i, pc});
            if (rel[i])   evq.push_back('{EV_REL, i, pc});
            if (hold[i])  evq.push_back('{EV_HOLD, i, pc});
            if (rpt[i])   evq.push_back('{EV_RPT, i, pc});
            if (clr)          heldm[i] = 1'b0;
            else if (hold[i]) heldm[i] = 1'b1;
            else if (rel[i])  heldm[i] = 1'b0;
            check("held", 32'(held[i]), 32'(heldm[i]));
        end
        check("excl", 32'((press & rel) | (hold & rpt)), 32'd0);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    function automatic int n_ev(input int kind, input int ch, input int from);
        int n = 0;
        foreach (evq[j]) if (evq[j].kind == kind && evq[j].ch == ch && evq[j].pc >= from) n++;
        return n;
    endfunction

    function automatic int t_ev(input int kind, input int ch, input int from, input int k);
        int n = 0;
        foreach (evq[j]) begin
            if (evq[j].kind == kind && evq[j].ch == ch && evq[j].pc >= from) begin
                if (n == k) return evq[j].pc;
                n++;
            end
        end
        return -1;
    endfunction

    // Ticks land on cycles rc+4, rc+8, ...; hold is the third tick strictly after press.
    function automatic int hold_at(input int p);
        return p + HOLD_MAX - ((p - rc) % TICK_DIV);
    endfunction

    task automatic check_stream(input string tag, input int ch, input int p, input int r);
        int h, nr;
        h  = hold_at(p);
        nr = 0;
        for (int t = h + RPT_GAP; t < r; t += RPT_GAP) nr++;
        check({tag, "_press"}, 32'(t_ev(EV_PRESS, ch, p, 0)), 32'(p));
        check({tag, "_npress"}, 32'(n_ev(EV_PRESS, ch, p)), 32'd1);
        check({tag, "_nhold"}, 32'(n_ev(EV_HOLD, ch, p)), 32'd1);
        check({tag, "_hold_t"}, 32'(t_ev(EV_HOLD, ch, p, 0)), 32'(h));
        check({tag, "_nrpt"}, 32'(n_ev(EV_RPT, ch, p)), 32'(nr));
        for (int k = 0; k < nr; k++)
            check({tag, "_rpt_t"}, 32'(t_ev(EV_RPT, ch, p, k)), 32'(h + RPT_GAP * (k + 1)));
        check({tag, "_rel_t"}, 32'(t_ev(EV_REL, ch, p, 0)), 32'(r));
        check({tag, "_nrel"}, 32'(n_ev(EV_REL, ch, p)), 32'd1);
    endtask

    initial begin
        int p, p1, h, ht, cs;

        // 1: reset with both buttons down, then press pulse on release of clr
        for (int i = 0; i < 3; i++) begin
            step();
            check("clr_quiet", 32'({press, rel, hold, rpt, held}), 32'd0);
        end
        clr = 1'b0;
        rc  = pc;
        step();
        check("rst_press", 32'(press), 32'd3);
        check("rst_norel", 32'(rel), 32'd0);
        step();
        check("press_1cyc", 32'(press), 32'd0);
        db_in = 2'b00;
        step();
        check("rel_both", 32'(rel), 32'd3);
        step();

        // 2: short press, no hold
        p = pc + 1;
        db_in = 2'b01;
        run(5);
        db_in = 2'b00;
        run(4);
        check("s2_press", 32'(t_ev(EV_PRESS, 0, p, 0)), 32'(p));
        check("s2_npress", 32'(n_ev(EV_PRESS, 0, p)), 32'd1);
        check("s2_rel", 32'(t_ev(EV_REL, 0, p, 0)), 32'(p + 5));
        check("s2_quiet", 32'(n_ev(EV_HOLD, 0, p) + n_ev(EV_RPT, 0, p)), 32'd0);

        // 3: long press on ch0 with repeats
        p = pc + 1;
        db_in = 2'b01;
        run(40);
        db_in = 2'b00;
        run(4);
        check_stream("s3", 0, p, p + 40);
        ht = t_ev(EV_HOLD, 0, p, 0);
        check("s3_hold_win", 32'((ht - p >= HOLD_MAX - TICK_DIV + 1) && (ht - p <= HOLD_MAX)), 32'd1);
        check("s3_ch1_quiet", 32'(n_ev(EV_PRESS, 1, p) + n_ev(EV_REL, 1, p)), 32'd0);

        // 4: release lands on the cycle hold would fire
        p = pc + 1;
        h = hold_at(p);
        db_in = 2'b01;
        run(h - p);
        db_in = 2'b00;
        run(4);
        check("s4_rel", 32'(t_ev(EV_REL, 0, p, 0)), 32'(h));
        check("s4_nohold", 32'(n_ev(EV_HOLD, 0, p) + n_ev(EV_RPT, 0, p)), 32'd0);

        // 5: staggered presses on both channels
        p  = pc + 1;
        p1 = p + 3;
        db_in = 2'b01;
        run(3);
        db_in = 2'b11;
        run(30);
        db_in = 2'b00;
        run(4);
        check_stream("s5c0", 0, p, p + 33);
        check_stream("s5c1", 1, p1, p + 33);

        // 6: clr while ch0 is repeating, button still down
        p = pc + 1;
        db_in = 2'b01;
        run(20);
        check("s6_in_rpt", 32'(held), 32'd1);
        clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("s6_clr_quiet", 32'({press, rel, hold, rpt, held}), 32'd0);
        end
        clr = 1'b0;
        rc  = pc;
        cs  = pc;
        step();
        check("s6_press", 32'(press), 32'd1);
        check("s6_norel", 32'(n_ev(EV_REL, 0, p)), 32'd0);
        db_in = 2'b00;
        run(3);
        check("s6_rel", 32'(t_ev(EV_REL, 0, cs, 0)), 32'(cs + 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
